padded_ifm_window_reader: RTL and testbench
===========================================

// Module: padded_ifm_window_reader
// PURPOSE
//  Read side of the padded-IFM buffer that control_padding_fused fills. Walks the padded feature
//  map (padded row-major, 16 channels per 128-bit word) in KxK sliding-window order with stride S.
//  Issues buffer read addresses and streams the returned words to the next conv engine over
//  valid/ready. Sits between the padded IFM BRAM and the PE array feeder.
// PARAMETERS
//  PE          16   channels per buffer word; C must be a multiple of PE
//  DATA_W      128  buffer word width (PE x 8 bit)
//  ADDR_W      32   buffer address width
//  RD_LAT      1    BRAM read latency, cycles (1 or 2)
//  FIFO_DEPTH  4    output skid FIFO depth; must be >= RD_LAT+2
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous reset, active-high
//  start         in   1       one-cycle pulse: latch config, begin layer
//  IFM_C         in   11      unpadded channel count
//  IFM_W         in   11      unpadded width = height (square map)
//  padding       in   1       P: 0 or 1 pixel border on each side
//  stride        in   2       S: 1 or 2
//  kernel        in   3       K: 1, 3 or 5
//  row_avail     in   11      padded rows fully written by the producer (monotonic per layer)
//  rd_en         out  1       buffer read strobe
//  rd_addr       out  ADDR_W  buffer read address
//  rd_data       in   DATA_W  buffer data, valid RD_LAT cycles after rd_en
//  m_valid       out  1       output word valid
//  m_ready       in   1       downstream accept
//  m_data        out  DATA_W  window word
//  m_last_tap    out  1       last word of the current window
//  m_last_win    out  1       last word of the layer
//  busy          out  1       high from the cycle after start until done
//  done          out  1       one-cycle pulse after the final beat is accepted
// BEHAVIOUR
//  Reset: all outputs 0. FSM goes to IDLE, FIFO is emptied, in-flight reads are discarded.
//    Reset has the same effect mid-layer.
//  Derived values, registered in SETUP:
//    CG   = IFM_C>>4
//    PW   = IFM_W + 2P
//    OW   = (PW-K)/S + 1
//    ROWW = PW*CG
//    Use 32-bit products; the ISSUE loop uses adders only, no multipliers.
//  Address of word (y, x, g) = y*ROWW + x*CG + g.
//  Loop order, outermost to innermost: oy, ox, ky, kx, g.
//    y = oy*S + ky
//    x = ox*S + kx
//  FSM states:
//    IDLE:      wait for start. start pulses in any other state are ignored.
//    SETUP:     1 cycle. Compute constants, clear counters, then go to WAIT_ROWS.
//    WAIT_ROWS: go to ISSUE once row_avail >= oy*S + K.
//    ISSUE:     assert rd_en when credit > 0, where credit = FIFO_DEPTH - occupancy - inflight.
//               - Advance g, kx, ky on each issue.
//               - At window end, advance ox. At row end, advance oy and return to WAIT_ROWS.
//               - After the last address of the layer, go to DRAIN.
//    DRAIN:     wait until inflight==0 and FIFO is empty with the last beat accepted; pulse done,
//               then go to IDLE.
//  Read data plus its tags (last_tap, last_win) travel through an RD_LAT delay line, then are
//    written into the FIFO.
//  m_* are driven from the FIFO head. A beat transfers when m_valid && m_ready.
//  m_valid, m_data and the tags stay stable until the beat is accepted.
//  A FIFO write and read in the same cycle are both allowed, including when the FIFO is full
//    (the read frees the slot).
//  The credit rule guarantees the FIFO never overflows. Any overflow is a design error; assert on it.
//  Degenerate cases:
//    - K > PW: OW <= 0. Go straight to done with zero beats.
//    - IFM_C < 16: treated as CG = 0, same zero-beat done.
//  Throughput: 1 word/cycle in steady state when m_ready=1 and rows are available.
// STRUCTURE
//  Package pad_buf_pkg, shared with control_padding_fused:
//    - PE, DATA_W, ADDR_W constants
//    - rd_state_t enum
//    - function pad_addr(y, x, g, ROWW, CG)
//  Sub-module ifm_rd_skid_fifo: synchronous FIFO of width DATA_W+2 and depth FIFO_DEPTH.
//    Ports: push, pop, full, empty, count.
// TESTING
//  1. C=16, W=4, P=1, K=3, S=1, row_avail=6, m_ready=1
//     -> 16 windows x 9 = 144 beats.
//     -> Window 0 addresses: 0,1,2,6,7,8,12,13,14.
//     -> m_last_tap on every 9th beat; m_last_win on beat 144; done the next cycle.
//  2. C=32, W=5, P=0, K=3, S=2
//     -> CG=2, OW=2, 4 windows x 18 beats.
//     -> Window 0 first addresses: 0,1,2,3,4,5,10,11.
//     -> Window 1 starts at address 4.
//  3. Case 1 with m_ready = 50% random
//     -> identical beat sequence, no loss or duplicates, data stable while stalled,
//        FIFO count <= FIFO_DEPTH.
//  4. Case 1 with row_avail=2
//     -> no rd_en issued.
//     -> Raise to 3: reads start within 2 cycles.
//     -> oy=1 waits until row_avail=4.
//  5. rst asserted mid-ISSUE for 1 cycle
//     -> next cycle: m_valid=0, rd_en=0, busy=0, FIFO empty.
//     -> A fresh start replays case 1 exactly.
//  6. start pulsed while busy -> ignored, the current layer completes unchanged.
//     K=5, W=2, P=1 -> done with zero beats.

Source files
------------

// File: rtl/pad_buf_pkg.sv
`default_nettype none
// pad_buf_pkg: constants, read-FSM states and the address helper shared by
// control_padding_fused (writer) and padded_ifm_window_reader (reader). Rev 1.0
package pad_buf_pkg;

  localparam int PE     = 16;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_WAIT_ROWS = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_DRAIN     = 3'd4
  } rd_state_t;

  // Word (y, x, g) in the padded, row-major, channel-group-interleaved buffer.
  function automatic logic [ADDR_W-1:0] pad_addr(
    input logic [ADDR_W-1:0] y,
    input logic [ADDR_W-1:0] x,
    input logic [ADDR_W-1:0] g,
    input logic [ADDR_W-1:0] roww,
    input logic [ADDR_W-1:0] cg
  );
    return y * roww + x * cg + g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifm_rd_skid_fifo.sv
`default_nettype none
// ifm_rd_skid_fifo: synchronous FIFO for returned buffer words plus tags; a push
// into a full FIFO is legal only together with a pop. Rev 1.0
module ifm_rd_skid_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule
`default_nettype wire

// File: rtl/padded_ifm_window_reader.sv
`default_nettype none
// padded_ifm_window_reader: walks the padded IFM buffer in KxK / stride-S window
// order and streams words to the PE feeder through a credit-guarded skid FIFO. Rev 1.0
module padded_ifm_window_reader #(
  parameter int PE         = pad_buf_pkg::PE,
  parameter int DATA_W     = pad_buf_pkg::DATA_W,
  parameter int ADDR_W     = pad_buf_pkg::ADDR_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [10:0]       IFM_C,
  input  logic [10:0]       IFM_W,
  input  logic              padding,
  input  logic [1:0]        stride,
  input  logic [2:0]        kernel,
  input  logic [10:0]       row_avail,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last_tap,
  output logic              m_last_win,
  output logic              busy,
  output logic              done
);
  import pad_buf_pkg::*;

  localparam int LOG_PE = $clog2(PE);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = CNT_W + 1;

  rd_state_t         state_q, state_d;
  logic [10:0]       cg_q, cg_d, w_q, w_d, g_q, g_d;
  logic              p_q, p_d, s2_q, s2_d;
  logic [2:0]        k_q, k_d, kx_q, kx_d, ky_q, ky_d;
  logic [11:0]       ow_q, ow_d, ox_q, ox_d, oy_q, oy_d, need_q, need_d;
  logic [ADDR_W-1:0] roww_q, roww_d, sroww_q, sroww_d, scg_q, scg_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, win_base_q, win_base_d;
  logic [ADDR_W-1:0] tap_row_q, tap_row_d, px_q, px_d;

  logic [11:0]       pw, diff, ow_calc;
  logic              zero_layer;
  logic [ADDR_W-1:0] cg_a, roww_calc, next_tap, next_win, next_row;
  logic              g_end, kx_end, ky_end, ox_end, oy_end, last_tap, last_win;

  logic [RD_LAT-1:0] vld_q;
  logic [1:0]        tag_q [RD_LAT];
  logic [OCC_W-1:0]  inflight, occ;
  logic              credit_ok;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W+1:0] fifo_head;

  assign pw         = {1'b0, w_q} + (p_q ? 12'd2 : 12'd0);
  assign zero_layer = (cg_q == '0) || ({9'd0, k_q} > pw);
  assign diff       = pw - {9'd0, k_q};
  assign ow_calc    = (s2_q ? {1'b0, diff[11:1]} : diff) + 12'd1;
  assign cg_a       = ADDR_W'(cg_q);
  assign roww_calc  = ADDR_W'(pw) * cg_a;

  assign next_tap = tap_row_q + roww_q;
  assign next_win = win_base_q + scg_q;
  assign next_row = row_base_q + sroww_q;

  assign g_end    = (g_q == cg_q - 11'd1);
  assign kx_end   = (kx_q == k_q - 3'd1);
  assign ky_end   = (ky_q == k_q - 3'd1);
  assign ox_end   = (ox_q == ow_q - 12'd1);
  assign oy_end   = (oy_q == ow_q - 12'd1);
  assign last_tap = g_end && kx_end && ky_end;
  assign last_win = last_tap && ox_end && oy_end;

  // Reads already issued but not yet in the FIFO still hold a slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(vld_q[i]);
  end
  assign occ       = OCC_W'(fifo_count) + inflight;
  assign credit_ok = (occ < OCC_W'(FIFO_DEPTH));

  assign rd_addr = px_q + ADDR_W'(g_q);
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cg_d       = cg_q;
    w_d        = w_q;
    p_d        = p_q;
    s2_d       = s2_q;
    k_d        = k_q;
    ow_d       = ow_q;
    roww_d     = roww_q;
    sroww_d    = sroww_q;
    scg_d      = scg_q;
    g_d        = g_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    need_d     = need_q;
    row_base_d = row_base_q;
    win_base_d = win_base_q;
    tap_row_d  = tap_row_q;
    px_d       = px_q;
    rd_en      = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cg_d    = IFM_C >> LOG_PE;
          w_d     = IFM_W;
          p_d     = padding;
          s2_d    = (stride == 2'd2);
          k_d     = kernel;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        ow_d       = ow_calc;
        roww_d     = roww_calc;
        sroww_d    = s2_q ? {roww_calc[ADDR_W-2:0], 1'b0} : roww_calc;
        scg_d      = s2_q ? {cg_a[ADDR_W-2:0], 1'b0} : cg_a;
        g_d        = '0;
        kx_d       = '0;
        ky_d       = '0;
        ox_d       = '0;
        oy_d       = '0;
        need_d     = {9'd0, k_q};
        row_base_d = '0;
        win_base_d = '0;
        tap_row_d  = '0;
        px_d       = '0;
        state_d    = zero_layer ? ST_DRAIN : ST_WAIT_ROWS;
      end
      ST_WAIT_ROWS: begin
        if ({1'b0, row_avail} >= need_q) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          if (!g_end) begin
            g_d = g_q + 11'd1;
          end else begin
            g_d = '0;
            if (!kx_end) begin
              kx_d = kx_q + 3'd1;
              px_d = px_q + cg_a;
            end else begin
              kx_d = '0;
              if (!ky_end) begin
                ky_d      = ky_q + 3'd1;
                tap_row_d = next_tap;
                px_d      = next_tap;
              end else begin
                ky_d = '0;
                if (!ox_end) begin
                  ox_d       = ox_q + 12'd1;
                  win_base_d = next_win;
                  tap_row_d  = next_win;
                  px_d       = next_win;
                end else begin
                  ox_d = '0;
                  if (!oy_end) begin
                    oy_d       = oy_q + 12'd1;
                    need_d     = need_q + (s2_q ? 12'd2 : 12'd1);
                    row_base_d = next_row;
                    win_base_d = next_row;
                    tap_row_d  = next_row;
                    px_d       = next_row;
                    state_d    = ST_WAIT_ROWS;
                  end else begin
                    state_d = ST_DRAIN;
                  end
                end
              end
            end
          end
        end
      end
      ST_DRAIN: begin
        if (inflight == '0 && fifo_empty) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cg_q       <= '0;
      w_q        <= '0;
      p_q        <= 1'b0;
      s2_q       <= 1'b0;
      k_q        <= '0;
      ow_q       <= '0;
      roww_q     <= '0;
      sroww_q    <= '0;
      scg_q      <= '0;
      g_q        <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      need_q     <= '0;
      row_base_q <= '0;
      win_base_q <= '0;
      tap_row_q  <= '0;
      px_q       <= '0;
    end else begin
      state_q    <= state_d;
      cg_q       <= cg_d;
      w_q        <= w_d;
      p_q        <= p_d;
      s2_q       <= s2_d;
      k_q        <= k_d;
      ow_q       <= ow_d;
      roww_q     <= roww_d;
      sroww_q    <= sroww_d;
      scg_q      <= scg_d;
      g_q        <= g_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      need_q     <= need_d;
      row_base_q <= row_base_d;
      win_base_q <= win_base_d;
      tap_row_q  <= tap_row_d;
      px_q       <= px_d;
    end
  end

  // Tags ride alongside the BRAM read so they meet their data at the FIFO input.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= 2'b00;
    end else begin
      vld_q[0] <= rd_en;
      tag_q[0] <= {last_tap, last_win};
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign fifo_push = vld_q[RD_LAT-1];
  assign fifo_pop  = m_valid && m_ready;

  ifm_rd_skid_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({tag_q[RD_LAT-1], rd_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign m_last_tap = !fifo_empty && fifo_head[DATA_W+1];
  assign m_last_win = !fifo_empty && fifo_head[DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_padded_ifm_window_reader.sv
`default_nettype none
// Scoreboard bench: directed layers push expected beats; a monitor pops and compares
// every accepted output word, its tags and its stability while stalled.
module tb_padded_ifm_window_reader;
  localparam int DW = 128;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, start, padding, m_ready;
  logic [10:0]   IFM_C, IFM_W, row_avail;
  logic [1:0]    stride;
  logic [2:0]    kernel;
  logic          rd_en, m_valid, m_last_tap, m_last_win, busy, done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, m_data;

  typedef struct packed {
    logic          tap;
    logic          win;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    got_addr[$];
  int    passed = 0, total = 0, beat_cnt = 0, rd_cnt = 0, cyc = 0, last_accept = -10;
  bit    rand_ready = 1'b0;

  always #5 clk = ~clk;

  padded_ifm_window_reader dut (
    .clk(clk), .rst(rst), .start(start), .IFM_C(IFM_C), .IFM_W(IFM_W),
    .padding(padding), .stride(stride), .kernel(kernel), .row_avail(row_avail),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last_tap(m_last_tap), .m_last_win(m_last_win), .busy(busy), .done(done)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a, a, a + 32'h1234_5678};
  endfunction

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Buffer model with one cycle of read latency.
  initial begin
    rd_data = '0;
    forever begin
      @(posedge clk);
      if (rd_en) rd_data <= mem_word(rd_addr);
    end
  end

  initial forever begin @(posedge clk); cyc++; end
  initial forever begin @(negedge clk); if (rd_en) rd_cnt++; end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    bit    stall;
    beat_t prev, cur, exp;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      cur = {m_last_tap, m_last_win, m_data};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) chk("stall_stable", {m_valid, cur}, {1'b1, prev});
        if (m_valid && m_ready) begin
          chk("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk("beat", cur, exp);
          end
          got_addr.push_back(int'(m_data[63:32]));
          beat_cnt++;
          last_accept = cyc;
        end
        stall = m_valid && !m_ready;
        prev  = cur;
      end
    end
  end

  task automatic set_cfg(input int c, input int w, input int p, input int k, input int s);
    IFM_C   = 11'(c);
    IFM_W   = 11'(w);
    padding = 1'(p);
    kernel  = 3'(k);
    stride  = 2'(s);
  endtask

  task automatic push_expected(input int c, input int w, input int p, input int k, input int s);
    int cg, pw, ow, roww;
    beat_t b;
    cg = c / 16;
    pw = w + 2 * p;
    roww = pw * cg;
    if (cg == 0 || k > pw) return;
    ow = (pw - k) / s + 1;
    for (int oy = 0; oy < ow; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++)
            for (int g = 0; g < cg; g++) begin
              b.data = mem_word(32'((oy * s + ky) * roww + (ox * s + kx) * cg + g));
              b.tap  = (ky == k - 1) && (kx == k - 1) && (g == cg - 1);
              b.win  = b.tap && (oy == ow - 1) && (ox == ow - 1);
              exp_q.push_back(b);
            end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, input bit has_beats);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, "_done"}, seen, 1);
    if (seen) begin
      if (has_beats) chk({name, "_done_latency"}, cyc - last_accept, 1);
      @(negedge clk);
      chk({name, "_done_pulse"}, {done, busy}, 2'b00);
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic run_layer(input string name, input int c, input int w, input int p,
                           input int k, input int s, input int ravail, input int nbeats);
    int b0;
    set_cfg(c, w, p, k, s);
    row_avail = 11'(ravail);
    got_addr.delete();
    push_expected(c, w, p, k, s);
    b0 = beat_cnt;
    pulse_start();
    wait_done(name, 5000, nbeats > 0);
    chk({name, "_beats"}, beat_cnt - b0, nbeats);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int a1[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    int a2[8] = '{0, 1, 2, 3, 4, 5, 10, 11};
    int b0, r0;
    bit seen;
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int a1[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    int a2[8] = '{0, 1, 2, 3, 4, 5, 10, 11};
    int b0, r0;
    bit seen;
    rst = 1'b1;
    start = 1'b0;
    row_avail = '0;
    set_cfg(16, 4, 1, 3, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rd", {rd_en, rd_addr}, 0);
    chk("reset_stream", {m_valid, m_last_tap, m_last_win, m_data}, 0);
    chk("reset_status", {busy, done}, 2'b00);

    // 3x3 stride 1 over a padded 6x6 map, one channel group.
    run_layer("c1", 16, 4, 1, 3, 1, 6, 144);
    for (int i = 0; i < 9; i++) chk($sformatf("c1_addr%0d", i), got_addr[i], a1[i]);

    // Stride 2, two channel groups, no padding.
    run_layer("c2", 32, 5, 0, 3, 2, 5, 72);
    for (int i = 0; i < 8; i++) chk($sformatf("c2_addr%0d", i), got_addr[i], a2[i]);
    chk("c2_win1_first", got_addr[18], 4);

    rand_ready = 1'b1;
    run_layer("c3", 16, 4, 1, 3, 1, 6, 144);
    rand_ready = 1'b0;

    // Row gating from the producer.
    set_cfg(16, 4, 1, 3, 1);
    row_avail = 11'd2;
    push_expected(16, 4, 1, 3, 1);
    b0 = beat_cnt;
    r0 = rd_cnt;
    pulse_start();
    repeat (20) @(negedge clk);
    chk("c4_no_reads", rd_cnt - r0, 0);
    chk("c4_busy", busy, 1);
    @(posedge clk); #1 row_avail = 11'd3;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rd_en) seen = 1'b1;
    end
    chk("c4_start_latency", seen, 1);
    repeat (80) @(negedge clk);
    chk("c4_row0_reads", rd_cnt - r0, 36);
    @(posedge clk); #1 row_avail = 11'd4;
    repeat (80) @(negedge clk);
    chk("c4_row1_reads", rd_cnt - r0, 72);
    @(posedge clk); #1 row_avail = 11'd6;
    wait_done("c4", 5000, 1);
    chk("c4_beats", beat_cnt - b0, 144);
    chk("c4_drained", exp_q.size(), 0);

    // Reset in the middle of a layer, then a clean replay.
    push_expected(16, 4, 1, 3, 1);
    pulse_start();
    repeat (30) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("c5_after_reset", {m_valid, rd_en, busy, done}, 4'b0000);
    run_layer("c5", 16, 4, 1, 3, 1, 6, 144);
    for (int i = 0; i < 9; i++) chk($sformatf("c5_addr%0d", i), got_addr[i], a1[i]);

    // A start while busy must not disturb the running layer.
    set_cfg(16, 4, 1, 3, 1);
    row_avail = 11'd6;
    push_expected(16, 4, 1, 3, 1);
    b0 = beat_cnt;
    pulse_start();
    repeat (10) @(negedge clk);
    set_cfg(16, 2, 1, 5, 1);
    pulse_start();
    wait_done("c6", 5000, 1);
    chk("c6_beats", beat_cnt - b0, 144);
    chk("c6_drained", exp_q.size(), 0);

    // Kernel larger than the padded map, then fewer than 16 channels.
    b0 = beat_cnt;
    r0 = rd_cnt;
    pulse_start();
    wait_done("c6_k_gt_pw", 50, 0);
    chk("c6_k_gt_pw_beats", beat_cnt - b0, 0);
    chk("c6_k_gt_pw_reads", rd_cnt - r0, 0);
    set_cfg(8, 4, 1, 3, 1);
    pulse_start();
    wait_done("c6_cg0", 50, 0);
    chk("c6_cg0_beats", beat_cnt - b0, 0);
    chk("c6_cg0_reads", rd_cnt - r0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
